// File: rtl/calc_entry_sequencer.sv
// Keypad-entry sequencer for the calculator datapath: turns debounced key events
// into operand load/clear strobes, an op select, and a start/done handshake with timeout.
module calc_entry_sequencer #(
  parameter int RELEASE_CYC = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       done,
  output logic [3:0] xin,
  output logic [3:0] yin,
  output logic       ldX,
  output logic       ldY,
  output logic       clrX,
  output logic       clrY,
  output logic [2:0] s,
  output logic       exec_start,
  output logic       busy,
  output logic       result_valid,
  output logic       err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_X    = 3'd0,
    S_OP   = 3'd1,
    S_Y    = 3'd2,
    S_EQ   = 3'd3,
    S_EXEC = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  localparam int         RW       = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYC - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          armed;
  logic [RW-1:0] rel_cnt;
  logic [7:0]    timer, timer_nxt;
  logic [3:0]    xin_nxt, yin_nxt;
  logic [2:0]    s_nxt;
  logic          ldx_nxt, ldy_nxt, clrx_nxt, clry_nxt, start_nxt, rv_nxt, err_nxt;

  logic accept, is_digit, is_op, is_clr, is_eq;
  logic [2:0] op_sel;

  assign accept   = key_valid && armed;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_clr   = (key_code == 4'd14);
  assign is_eq    = (key_code == 4'd15);
  // codes 10..13 map to 0..3 through their low two bits
  assign op_sel   = {1'b0, key_code[1:0] - 2'd2};

  assign busy    = (state == S_EXEC);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_X;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    xin_nxt   = xin;
    yin_nxt   = yin;
    s_nxt     = s;
    rv_nxt    = result_valid;
    err_nxt   = err;
    ldx_nxt   = 1'b0;
    ldy_nxt   = 1'b0;
    clrx_nxt  = 1'b0;
    clry_nxt  = 1'b0;
    start_nxt = 1'b0;
    if (accept && is_clr) begin
      clrx_nxt  = 1'b1;
      clry_nxt  = 1'b1;
      s_nxt     = 3'd0;
      rv_nxt    = 1'b0;
      err_nxt   = 1'b0;
      timer_nxt = 8'd0;
      state_nxt = S_X;
    end else begin
      case (state)
        S_X: if (accept && is_digit) begin
          xin_nxt   = key_code;
          ldx_nxt   = 1'b1;
          state_nxt = S_OP;
        end
        S_OP: if (accept && is_digit) begin
          xin_nxt = key_code;
          ldx_nxt = 1'b1;
        end else if (accept && is_op) begin
          s_nxt     = op_sel;
          state_nxt = S_Y;
        end
        S_Y: if (accept && is_digit) begin
          yin_nxt   = key_code;
          ldy_nxt   = 1'b1;
          state_nxt = S_EQ;
        end else if (accept && is_op) begin
          s_nxt = op_sel;
        end
        S_EQ: if (accept && is_digit) begin
          yin_nxt = key_code;
          ldy_nxt = 1'b1;
        end else if (accept && is_op) begin
          s_nxt = op_sel;
        end else if (accept && is_eq) begin
          start_nxt = 1'b1;
          timer_nxt = 8'd0;
          state_nxt = S_EXEC;
        end
        S_EXEC: if (done) begin
          rv_nxt    = 1'b1;
          state_nxt = S_SHOW;
        end else if (timer == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_SHOW;
        end else if (timer != 8'hFF) begin
          timer_nxt = timer + 8'd1;
        end
        // a digit starts a fresh entry; an operator chains onto the held result in X
        S_SHOW: if (accept && is_digit) begin
          rv_nxt    = 1'b0;
          err_nxt   = 1'b0;
          xin_nxt   = key_code;
          ldx_nxt   = 1'b1;
          clry_nxt  = 1'b1;
          state_nxt = S_OP;
        end else if (accept && is_op) begin
          rv_nxt    = 1'b0;
          err_nxt   = 1'b0;
          s_nxt     = op_sel;
          state_nxt = S_Y;
        end
        default: state_nxt = S_X;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xin          <= 4'd0;
      yin          <= 4'd0;
      s            <= 3'd0;
      ldX          <= 1'b0;
      ldY          <= 1'b0;
      clrX         <= 1'b0;
      clrY         <= 1'b0;
      exec_start   <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      timer        <= 8'd0;
    end else begin
      xin          <= xin_nxt;
      yin          <= yin_nxt;
      s            <= s_nxt;
      ldX          <= ldx_nxt;
      ldY          <= ldy_nxt;
      clrX         <= clrx_nxt;
      clrY         <= clry_nxt;
      exec_start   <= start_nxt;
      result_valid <= rv_nxt;
      err          <= err_nxt;
      timer        <= timer_nxt;
    end
  end

  // Re-arm only after key_valid stays low for RELEASE_CYC consecutive cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b1;
      rel_cnt <= '0;
    end else if (accept) begin
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else if (!armed) begin
      if (key_valid) begin
        rel_cnt <= '0;
      end else if (rel_cnt == REL_LAST) begin
        armed   <= 1'b1;
        rel_cnt <= '0;
      end else begin
        rel_cnt <= rel_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: key entry, debounce, timeout, clear/done race,
// chained operation and asynchronous reset.
module tb_calc_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       done = 1'b0;
  logic [3:0] xin, yin;
  logic       ldX, ldY, clrX, clrY, exec_start, busy, result_valid, err;
  logic [2:0] s, state_o;
  logic [21:0] all_outs;

  int tests_run = 0;
  int tests_failed = 0;
  int n_ldx, n_ldy, n_clrx, n_clry, n_start, n_busy, n_conflict;
  logic [3:0] last_xin, last_yin;

  calc_entry_sequencer #(.RELEASE_CYC(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .done(done),
    .xin(xin), .yin(yin), .ldX(ldX), .ldY(ldY), .clrX(clrX), .clrY(clrY), .s(s),
    .exec_start(exec_start), .busy(busy), .result_valid(result_valid), .err(err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign all_outs = {xin, yin, ldX, ldY, clrX, clrY, s, exec_start, busy,
                     result_valid, err, state_o};

  // Pulse counters sampled mid-cycle so one-cycle strobes are never missed
  always @(negedge clk) begin
    if (ldX) begin n_ldx++; last_xin = xin; end
    if (ldY) begin n_ldy++; last_yin = yin; end
    if (clrX) n_clrx++;
    if (clrY) n_clry++;
    if (exec_start) n_start++;
    if (busy) n_busy++;
    if ((ldX && clrX) || (ldY && clrY)) n_conflict++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clearCounts;
    n_ldx = 0; n_ldy = 0; n_clrx = 0; n_clry = 0;
    n_start = 0; n_busy = 0; n_conflict = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] code, input int hold, input int rel);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    repeat (rel) tick();
  endtask

  // Equals, then done raised on the fourth busy cycle, then enough idle to re-arm
  task automatic runEquals;
    key_code  = 4'd15;
    key_valid = 1'b1;
    tick();
    checkOutput("exec entry state", 32'(state_o), 32'd4);
    checkOutput("exec_start pulse", 32'(exec_start), 32'd1);
    tick();
    tick();
    key_valid = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    clearCounts();
    last_xin = 4'd0;
    last_yin = 4'd0;
    #12;
    checkOutput("reset outputs", 32'(all_outs), 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] basic entry 7 + 5 =");
    applyStimulus(4'd7, 3, 6);
    checkOutput("t1 ldX count", n_ldx, 1);
    checkOutput("t1 xin", 32'(last_xin), 32'd7);
    checkOutput("t1 state OP", 32'(state_o), 32'd1);
    applyStimulus(4'd10, 3, 6);
    checkOutput("t1 s add", 32'(s), 32'd0);
    checkOutput("t1 state Y", 32'(state_o), 32'd2);
    applyStimulus(4'd5, 3, 6);
    checkOutput("t1 ldY count", n_ldy, 1);
    checkOutput("t1 yin", 32'(last_yin), 32'd5);
    checkOutput("t1 state EQ", 32'(state_o), 32'd3);
    runEquals();
    checkOutput("t1 start count", n_start, 1);
    checkOutput("t1 busy cycles", n_busy, 4);
    checkOutput("t1 result_valid", 32'(result_valid), 32'd1);
    checkOutput("t1 err", 32'(err), 32'd0);
    checkOutput("t1 state SHOW", 32'(state_o), 32'd5);

    $display("[TB] chained sub 2 =");
    clearCounts();
    applyStimulus(4'd11, 3, 6);
    checkOutput("t5 s sub", 32'(s), 32'd1);
    checkOutput("t5 state Y", 32'(state_o), 32'd2);
    checkOutput("t5 rv cleared", 32'(result_valid), 32'd0);
    applyStimulus(4'd2, 3, 6);
    checkOutput("t5 yin", 32'(last_yin), 32'd2);
    runEquals();
    checkOutput("t5 no ldX", n_ldx, 0);
    checkOutput("t5 ldY count", n_ldy, 1);
    checkOutput("t5 start count", n_start, 1);
    checkOutput("t5 result_valid", 32'(result_valid), 32'd1);

    $display("[TB] clear then bouncing digit");
    clearCounts();
    applyStimulus(4'd14, 3, 6);
    checkOutput("clr state X", 32'(state_o), 32'd0);
    checkOutput("clr clrX count", n_clrx, 1);
    checkOutput("clr s zero", 32'(s), 32'd0);
    clearCounts();
    key_code = 4'd3;
    for (int i = 0; i < 22; i++) begin
      key_valid = !(i == 8 || i == 9);
      tick();
    end
    key_valid = 1'b0;
    repeat (6) tick();
    checkOutput("t2 ldX count", n_ldx, 1);
    checkOutput("t2 xin", 32'(last_xin), 32'd3);
    checkOutput("t2 state OP", 32'(state_o), 32'd1);

    $display("[TB] timeout with no done");
    applyStimulus(4'd10, 3, 6);
    applyStimulus(4'd4, 3, 6);
    clearCounts();
    key_code  = 4'd15;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    checkOutput("t3 exec entry", 32'(state_o), 32'd4);
    repeat (254) tick();
    checkOutput("t3 still exec", 32'(state_o), 32'd4);
    checkOutput("t3 no early err", 32'(err), 32'd0);
    tick();
    checkOutput("t3 state SHOW", 32'(state_o), 32'd5);
    checkOutput("t3 err", 32'(err), 32'd1);
    checkOutput("t3 result_valid", 32'(result_valid), 32'd0);
    checkOutput("t3 busy cycles", n_busy, 255);

    $display("[TB] clear races done in EXEC");
    clearCounts();
    applyStimulus(4'd6, 3, 6);
    checkOutput("t4 err cleared", 32'(err), 32'd0);
    checkOutput("t4 clrY on new entry", n_clry, 1);
    checkOutput("t4 xin", 32'(last_xin), 32'd6);
    applyStimulus(4'd10, 3, 6);
    applyStimulus(4'd1, 3, 6);
    key_code  = 4'd15;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    checkOutput("t4 exec entry", 32'(state_o), 32'd4);
    repeat (4) tick();
    key_code  = 4'd14;
    key_valid = 1'b1;
    done      = 1'b1;
    tick();
    checkOutput("t4 clrX", 32'(clrX), 32'd1);
    checkOutput("t4 clrY", 32'(clrY), 32'd1);
    checkOutput("t4 no ldX", 32'(ldX), 32'd0);
    checkOutput("t4 state X", 32'(state_o), 32'd0);
    checkOutput("t4 rv", 32'(result_valid), 32'd0);
    key_valid = 1'b0;
    done      = 1'b0;
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checkOutput("t4 late done state", 32'(state_o), 32'd0);
    checkOutput("t4 late done rv", 32'(result_valid), 32'd0);
    repeat (6) tick();

    $display("[TB] async reset in S_Y");
    applyStimulus(4'd8, 3, 6);
    applyStimulus(4'd12, 3, 6);
    checkOutput("t6 s mul", 32'(s), 32'd2);
    checkOutput("t6 state Y", 32'(state_o), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("t6 async reset outs", 32'(all_outs), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    clearCounts();
    applyStimulus(4'd9, 3, 6);
    checkOutput("t6 ldX after reset", n_ldx, 1);
    checkOutput("t6 xin after reset", 32'(last_xin), 32'd9);
    checkOutput("t6 state OP", 32'(state_o), 32'd1);
    checkOutput("strobe exclusivity", n_conflict, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
